// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store control unit: funct3 codes, FSM
// states and the request legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

  // Legal when the size code exists for the direction, the access is
  // naturally aligned, and no address bit above the implemented range is set.
  function automatic logic is_legal(input logic        we,
                                    input logic [2:0]  funct3,
                                    input logic [31:0] addr,
                                    input int unsigned addr_w);
    logic ok;
    case (funct3)
      F3_B, F3_BU: ok = 1'b1;
      F3_H, F3_HU: ok = ~addr[0];
      F3_W:        ok = (addr[1:0] == 2'b00);
      default:     ok = 1'b0;
    endcase
    if (we && funct3[2]) ok = 1'b0;
    if ((addr_w < 32) && ((addr >> addr_w) != 32'd0)) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data alignment: load extraction/extension and the
// sub-word store merge into the previously read word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  // Load result: pick the low byte/half of the read word and extend it.
  always_comb begin
    load_data = '0;
    case (funct3)
      F3_B:    load_data = {{24{word[7]}}, word[7:0]};
      F3_BU:   load_data = {24'd0, word[7:0]};
      F3_H:    load_data = {{16{word[15]}}, word[15:0]};
      F3_HU:   load_data = {16'd0, word[15:0]};
      F3_W:    load_data = word;
      default: load_data = '0;
    endcase
  end

  // Store word: replace only the addressed low byte/half, keep the rest.
  always_comb begin
    store_data = wdata;
    case (funct3[1:0])
      2'b00:   store_data = {word[31:8], wdata[7:0]};
      2'b01:   store_data = {word[31:16], wdata[15:0]};
      default: store_data = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control unit: accepts one request at a time, sequences the
// data-memory read / write cycles and returns a valid/ready response.
//
// state | meaning
// IDLE  | waiting for a request, req_ready=1
// RD    | memory read, word captured into word_q
// WR    | single-cycle memory write (full word or merged sub-word)
// RESP  | response held until resp_ready
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd
);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic        err_q, err_d;
  logic [31:0] load_data;
  logic [31:0] store_data;

  lsu_align u_align (
    .funct3     (f3_q),
    .word       (word_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_data (store_data)
  );

  // Next-state, request latching and all FSM-driven outputs.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    f3_d       = f3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    word_d     = word_q;
    err_d      = err_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    mem_addr   = addr_q;
    mem_wd     = '0;
    mem_we     = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          err_d   = ~is_legal(req_we, req_funct3, req_addr, ADDR_W);
          if (err_d)                    state_d = RESP;
          else if (!req_we)             state_d = RD;
          else if (req_funct3 == F3_W)  state_d = WR;
          else                          state_d = RD;
        end
      end
      RD: begin
        word_d  = mem_rd;
        state_d = we_q ? WR : RESP;
      end
      WR: begin
        mem_we  = 1'b1;
        mem_wd  = store_data;
        state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (err_q || we_q) ? 32'd0 : load_data;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and request registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed table, multi-cycle corner sequences and
// randomized requests against a byte-level reference memory model.
module tb_lsu_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wd, mem_rd;

  always #5 CLK = ~CLK;

  lsu_ctrl #(.ADDR_W(16)) dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  // Data memory seen by the DUT (64 KiB, wrapping) and the reference copy.
  logic [7:0]  mem     [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic        mem_clr = 1'b0, pre_we = 1'b0;
  logic [31:0] pre_addr = '0, pre_data = '0;
  int          we_total = 0;

  always_comb begin
    logic [15:0] a;
    a = mem_addr[15:0];
    mem_rd = {mem[a + 16'd3], mem[a + 16'd2], mem[a + 16'd1], mem[a]};
  end

  always @(posedge CLK) begin
    logic [15:0] a;
    if (mem_clr) begin
      for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;
    end else if (mem_we) begin
      a = mem_addr[15:0];
      mem[a] <= mem_wd[7:0];          mem[a + 16'd1] <= mem_wd[15:8];
      mem[a + 16'd2] <= mem_wd[23:16]; mem[a + 16'd3] <= mem_wd[31:24];
    end else if (pre_we) begin
      a = pre_addr[15:0];
      mem[a] <= pre_data[7:0];          mem[a + 16'd1] <= pre_data[15:8];
      mem[a + 16'd2] <= pre_data[23:16]; mem[a + 16'd3] <= pre_data[31:24];
    end
    if (mem_we) we_total <= we_total + 1;
  end

  int n_vec = 0, n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model (byte arithmetic) ----------------
  function automatic logic [31:0] ref_word(input logic [31:0] addr);
    logic [15:0] i;
    i = addr[15:0];
    return 32'(ref_mem[i]) + 32'(ref_mem[i + 16'd1]) * 256 +
           32'(ref_mem[i + 16'd2]) * 65536 + 32'(ref_mem[i + 16'd3]) * 16777216;
  endfunction

  function automatic logic ref_legal(input logic we, input int f3, input logic [31:0] addr);
    if (!(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) return 1'b0;
    if (we && f3 >= 4) return 1'b0;
    if ((f3 == 1 || f3 == 5) && (addr % 2 != 0)) return 1'b0;
    if (f3 == 2 && (addr % 4 != 0)) return 1'b0;
    if (addr >= 32'd65536) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] ref_load(input int f3, input logic [31:0] addr);
    logic [31:0] w, b, h;
    w = ref_word(addr);
    b = w % 256;
    h = w % 65536;
    case (f3)
      0: return (b >= 128) ? b - 32'd256 : b;
      4: return b;
      1: return (h >= 32768) ? h - 32'd65536 : h;
      5: return h;
      default: return w;
    endcase
  endfunction

  task automatic ref_store(input int f3, input logic [31:0] addr, input logic [31:0] wd);
    logic [15:0] i;
    int n;
    i = addr[15:0];
    n = (f3 == 0) ? 1 : (f3 == 1) ? 2 : 4;
    for (int k = 0; k < n; k++) ref_mem[i + 16'(k)] = 8'((wd >> (8 * k)) % 256);
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] val);
    @(negedge CLK);
    pre_addr = addr; pre_data = val; pre_we = 1'b1;
    @(posedge CLK);
    #1 pre_we = 1'b0;
    for (int k = 0; k < 4; k++) ref_mem[addr[15:0] + 16'(k)] = 8'((val >> (8 * k)) % 256);
  endtask

  // One full request/response; lat counts cycles from accept edge to resp_valid.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat, output logic err,
                        output logic [31:0] rd, output int wecnt, output logic [31:0] wdat);
    bit got;
    lat = 99; err = 1'bx; rd = 'x; wecnt = 0; wdat = '0; got = 0;
    @(negedge CLK);
    for (int c = 0; c < 10 && !req_ready; c++) @(negedge CLK);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge CLK);
    for (int c = 1; c <= 12 && !got; c++) begin
      @(negedge CLK);
      req_valid = 1'b0;
      if (mem_we) begin wecnt++; wdat = mem_wd; end
      if (resp_valid) begin got = 1; lat = c; err = resp_err; rd = resp_rdata; end
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge CLK);
    #1 resp_ready = 1'b0;
  endtask

  task automatic run_one(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic e_err, input logic [31:0] e_rd, input int e_lat,
                         input int e_we, input bit chk_wd, input logic [31:0] e_wd);
    int lat, wecnt;
    logic err;
    logic [31:0] rd, wdat;
    do_req(we, f3, addr, wd, lat, err, rd, wecnt, wdat);
    check({name, " latency"}, lat, e_lat);
    check({name, " err"}, {31'd0, err}, {31'd0, e_err});
    check({name, " rdata"}, rd, e_rd);
    check({name, " mem_we cycles"}, wecnt, e_we);
    if (chk_wd) check({name, " mem_wd"}, wdat, e_wd);
    if (we && !e_err) ref_store(int'(f3), addr, wd);
    check({name, " memory word"},
          {mem[addr[15:0] + 16'd3], mem[addr[15:0] + 16'd2], mem[addr[15:0] + 16'd1], mem[addr[15:0]]},
          ref_word(addr));
  endtask

  typedef struct {
    string       name;
    logic        pre;
    logic [31:0] pre_val;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          wecnt;
    logic [31:0] wd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string nm, logic pre, logic [31:0] pv, logic we, logic [2:0] f3,
                              logic [31:0] a, logic [31:0] wd, logic e, logic [31:0] rd,
                              int lat, int wc, logic [31:0] ewd);
    vec_t v;
    v.name = nm; v.pre = pre; v.pre_val = pv; v.we = we; v.f3 = f3; v.addr = a;
    v.wdata = wd; v.err = e; v.rdata = rd; v.lat = lat; v.wecnt = wc; v.wd = ewd;
    return v;
  endfunction

  initial begin
    int lat, wecnt, we0;
    logic err;
    logic [31:0] rd, wdat, a, wd;
    logic we;
    logic [2:0] f3;
    bit got;

    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;
    mem_clr = 1'b1;
    repeat (2) @(posedge CLK);
    #1 mem_clr = 1'b0;
    @(negedge CLK);
    check("reset req_ready", {31'd0, req_ready}, 32'd1);
    check("reset resp_valid", {31'd0, resp_valid}, 32'd0);
    check("reset resp_err", {31'd0, resp_err}, 32'd0);
    check("reset resp_rdata", resp_rdata, 32'd0);
    check("reset mem_we", {31'd0, mem_we}, 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset mem_wd", mem_wd, 32'd0);
    RST = 1'b0;

    tbl.push_back(mk("lw 2000", 1, 32'h0000000A, 0, 3'b010, 32'h2000, 0, 0, 32'h0000000A, 2, 0, 0));
    tbl.push_back(mk("lb 200C", 1, 32'h11223380, 0, 3'b000, 32'h200C, 0, 0, 32'hFFFFFF80, 2, 0, 0));
    tbl.push_back(mk("lbu 200C", 0, 0, 0, 3'b100, 32'h200C, 0, 0, 32'h00000080, 2, 0, 0));
    tbl.push_back(mk("lh 200C", 0, 0, 0, 3'b001, 32'h200C, 0, 0, 32'h00003380, 2, 0, 0));
    tbl.push_back(mk("lhu 200C", 0, 0, 0, 3'b101, 32'h200C, 0, 0, 32'h00003380, 2, 0, 0));
    tbl.push_back(mk("sb 200C", 1, 32'h11223344, 1, 3'b000, 32'h200C, 32'hAABBCCDD, 0, 0, 3, 1, 32'h112233DD));
    tbl.push_back(mk("lw after sb", 0, 0, 0, 3'b010, 32'h200C, 0, 0, 32'h112233DD, 2, 0, 0));
    tbl.push_back(mk("err lh 2001", 0, 0, 0, 3'b001, 32'h2001, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk("err sw 2002", 0, 0, 1, 3'b010, 32'h2002, 32'h12345678, 1, 0, 1, 0, 0));
    tbl.push_back(mk("err store f3=100", 0, 0, 1, 3'b100, 32'h2000, 32'h12345678, 1, 0, 1, 0, 0));
    tbl.push_back(mk("err lw 10000", 0, 0, 0, 3'b010, 32'h00010000, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk("err f3=011", 0, 0, 0, 3'b011, 32'h2000, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk("sw 2010", 1, 32'h0, 1, 3'b010, 32'h2010, 32'hDEADBEEF, 0, 0, 2, 1, 32'hDEADBEEF));
    tbl.push_back(mk("sh 2012", 0, 0, 1, 3'b001, 32'h2012, 32'h1234CAFE, 0, 0, 3, 1, 32'h0000CAFE));
    tbl.push_back(mk("lw 2010", 0, 0, 0, 3'b010, 32'h2010, 0, 0, 32'hCAFEBEEF, 2, 0, 0));
    tbl.push_back(mk("lh 2012", 0, 0, 0, 3'b001, 32'h2012, 0, 0, 32'hFFFFCAFE, 2, 0, 0));
    tbl.push_back(mk("lb 2013", 0, 0, 0, 3'b000, 32'h2013, 0, 0, 32'hFFFFFFCA, 2, 0, 0));
    tbl.push_back(mk("sb FFFF", 0, 0, 1, 3'b000, 32'h0000FFFF, 32'h0000005A, 0, 0, 3, 1, 32'h0000005A));
    tbl.push_back(mk("lbu FFFF", 0, 0, 0, 3'b100, 32'h0000FFFF, 0, 0, 32'h0000005A, 2, 0, 0));

    foreach (tbl[i]) begin
      if (tbl[i].pre) preload(tbl[i].addr, tbl[i].pre_val);
      run_one(tbl[i].name, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, tbl[i].err,
              tbl[i].rdata, tbl[i].lat, tbl[i].wecnt, tbl[i].wecnt == 1, tbl[i].wd);
    end

    // Response back-pressure, then a request arriving together with resp_ready.
    preload(32'h2040, 32'h0BADF00D);
    preload(32'h2044, 32'h000000F0);
    @(negedge CLK);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h2040;
    @(posedge CLK);
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge CLK);
      req_funct3 = 3'b000; req_addr = 32'h2044;
      if (resp_valid) got = 1;
    end
    check("hold reached resp", {31'd0, got}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      check("hold resp_valid", {31'd0, resp_valid}, 32'd1);
      check("hold resp_rdata", resp_rdata, 32'h0BADF00D);
      check("hold req_ready", {31'd0, req_ready}, 32'd0);
      @(negedge CLK);
    end
    resp_ready = 1'b1;
    @(posedge CLK);
    #1 resp_ready = 1'b0;
    @(negedge CLK);
    check("bubble req_ready", {31'd0, req_ready}, 32'd1);
    check("bubble resp_valid", {31'd0, resp_valid}, 32'd0);
    @(negedge CLK);
    req_valid = 1'b0;
    check("after accept req_ready", {31'd0, req_ready}, 32'd0);
    got = 0; lat = 99;
    for (int c = 1; c <= 10 && !got; c++) begin
      if (resp_valid) begin got = 1; lat = c; rd = resp_rdata; end
      else @(negedge CLK);
    end
    check("queued lb latency", lat, 2);
    check("queued lb rdata", rd, 32'hFFFFFFF0);
    resp_ready = 1'b1;
    @(posedge CLK);
    #1 resp_ready = 1'b0;

    // Reset during the read phase of a sub-word store.
    preload(32'h2020, 32'h55667788);
    we0 = we_total;
    @(negedge CLK);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h2020; req_wdata = 32'h1234;
    @(posedge CLK);
    @(negedge CLK);
    req_valid = 1'b0;
    check("rst-in-RD mem_we", {31'd0, mem_we}, 32'd0);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("rst-in-RD req_ready", {31'd0, req_ready}, 32'd1);
    check("rst-in-RD resp_valid", {31'd0, resp_valid}, 32'd0);
    repeat (3) @(negedge CLK);
    check("rst-in-RD no write", we_total - we0, 32'd0);
    run_one("lw after rst", 0, 3'b010, 32'h2020, 0, 0, 32'h55667788, 2, 0, 0, 0);

    // Randomized requests against the reference model.
    for (int i = 0; i < 16; i++) preload(32'h3000 + 32'(4 * i), $urandom);
    for (int n = 0; n < 250; n++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      wd = $urandom;
      case ($urandom_range(0, 15))
        0:       a = 32'h00010000 | 32'($urandom_range(0, 255)) << $urandom_range(0, 15);
        1:       a = 32'h0000FFFC + 32'($urandom_range(0, 3));
        default: a = 32'h3000 + 32'($urandom_range(0, 63));
      endcase
      if (!ref_legal(we, int'(f3), a))
        run_one("rand err", we, f3, a, wd, 1, 0, 1, 0, 0, 0);
      else if (!we)
        run_one("rand load", we, f3, a, wd, 0, ref_load(int'(f3), a), 2, 0, 0, 0);
      else
        run_one("rand store", we, f3, a, wd, 0, 0, (f3 == 3'b010) ? 2 : 3, 1, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
